bsg_mul_share_ctrl: RTL and testbench
=====================================

BSG_MUL_SHARE_CTRL -- requirements
Module: bsg_mul_share_ctrl

Interface
REQ-001 SHALL have parameter width_p, default 128: operand width.
REQ-002 SHALL have parameter els_p, default 2: number of requesters (>=2).
REQ-003 SHALL have parameter lat_p, default 4: multiplier latency in enabled cycles (>=1).
REQ-004 SHALL have ports, one clock; reset is synchronous and active-high:
  clk_i  in  1  clock
  reset_i  in  1  sync active-high reset
  v_i  in  els_p  per-requester operand valid
  x_i  in  els_p*width_p  per-requester multiplicand
  y_i  in  els_p*width_p  per-requester multiplier
  signed_i  in  els_p  per-requester signed select
  ready_o  out  els_p  one-hot accept; a requester's transfer occurs when v_i&ready_o
  mul_en_o  out  1  pipeline enable to the shared multiplier
  mul_x_o  out  width_p  operand to multiplier
  mul_y_o  out  width_p  operand to multiplier
  mul_signed_o  out  1  signed select to multiplier
  mul_z_i  in  2*width_p  product from multiplier
  v_o  out  1  result valid
  z_o  out  2*width_p  result (= mul_z_i)
  id_o  out  log2(els_p)  requester index of result
  yumi_i  in  1  consumer takes result; only legal when v_o=1

Function
REQ-005 SHALL hold a lat_p-deep shift register of valid bits and requester ids shadowing the multiplier pipeline.
REQ-006 SHALL define advance = !v_o | yumi_i; mul_en_o SHALL equal advance.
REQ-007 SHALL shift valid/id by one stage on every cycle with advance=1 and hold them otherwise.
REQ-008 SHALL, when advance=1 and any v_i set, grant exactly one requester by round-robin and assert its ready_o bit combinationally in the same cycle.
REQ-009 SHALL drive ready_o=0 for all requesters when advance=0 or reset_i=1.
REQ-010 SHALL mux the granted requester's x_i, y_i, signed_i onto mul_x_o, mul_y_o, mul_signed_o; stage-0 valid loads 1 and stage-0 id loads grant index on that cycle.
REQ-011 SHALL load stage-0 valid=0 on an advancing cycle with no grant (bubble).
REQ-012 SHALL drive v_o from the last valid stage and id_o from the last id stage; result appears exactly lat_p advancing cycles after acceptance.
REQ-013 SHALL keep v_o, z_o, id_o stable while v_o=1 and yumi_i=0 (entire pipeline frozen).
REQ-014 SHALL allow accept and yumi_i in the same cycle, giving full throughput of one result per cycle.
REQ-015 Round-robin: priority pointer starts at 0, after a grant moves to grant+1 (mod els_p), unchanged when no grant; no requester waits more than els_p-1 grants.
REQ-016 SHALL deliver results in acceptance order; no reordering.

Reset
REQ-017 SHALL, on reset_i=1 at a clock edge, clear all valid stages and set priority pointer to 0; in-flight operations are discarded with no result.
REQ-018 SHALL produce v_o=0, ready_o=0, id_o=0 the cycle after reset; multiplier data contents are don't-care, masked by valid.

Configuration
REQ-019 With BSG_MUL_SHARE_CTRL_PERF_EN defined, SHALL add outputs issue_count_o[31:0] (accepted ops) and stall_count_o[31:0] (cycles with advance=0), both cleared by reset, wrapping at 2^32.
REQ-020 Without BSG_MUL_SHARE_CTRL_PERF_EN, SHALL still present both ports, tied to 0, with no counter logic.

Structure
REQ-021 SHALL place default width/latency constants and the requester-id width function in shared package bsg_mul_share_pkg.
REQ-022 SHALL instantiate one sub-module, bsg_arb_round_robin, for grant generation; multiplier itself stays outside.

Verification
REQ-023 Bench SHALL pair the block with bsg_mul_pipelined (lat_p=4) and cover:
  - Req0 x=3,y=5 unsigned, yumi_i=1 -> v_o after 4 cycles, z_o=15, id_o=0.
  - Req1 x=-2 (all ones except LSB 0),y=3, signed -> z_o=-6 as 256-bit two's complement, id_o=1.
  - Both requesters valid 6 cycles -> grants 0,1,0,1,0,1; results in that order, one per cycle.
  - v_o=1, yumi_i=0 for 3 cycles -> mul_en_o=0, ready_o=0, z_o/id_o held; resumes on yumi_i=1 with no loss.
  - 2 ops in flight, reset_i pulsed -> no v_o afterwards; next op granted to req0 first.
  - PERF_EN build: 5 accepts + 3 stall cycles -> issue_count_o=5, stall_count_o=3; non-PERF build reads 0.

Source files
------------

// File: rtl/bsg_mul_share_pkg.sv
// Shared defaults and helpers for the shared-multiplier controller and its arbiter.
package bsg_mul_share_pkg;

    localparam int WidthDefault = 128;
    localparam int ElsDefault   = 2;
    localparam int LatDefault   = 4;

    // A single requester still needs a one-bit id field.
    function automatic int id_width(input int els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin grant generator: one-hot grant among enabled requests, priority rotating past the winner.
module bsg_arb_round_robin
    import bsg_mul_share_pkg::*;
#(
    parameter int els_p = ElsDefault
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_en,
    input  logic [els_p-1:0]           i_reqs,
    output logic [els_p-1:0]           o_grants,
    output logic [id_width(els_p)-1:0] o_grant_id,
    output logic                       o_v
);

    localparam int IdW = id_width(els_p);
    localparam logic [IdW-1:0] LastId = IdW'(els_p - 1);

    logic [IdW-1:0]   r_ptr;
    logic [IdW-1:0]   w_idx;
    logic [els_p-1:0] w_reqs;

    function automatic int wrap_idx(input int idx);
        return (idx >= els_p) ? idx - els_p : idx;
    endfunction

    assign w_reqs = i_reqs & {els_p{i_en}};

    // Scan requesters starting at the priority pointer; the first hit wins.
    always_comb begin
        o_grants   = '0;
        o_grant_id = '0;
        o_v        = 1'b0;
        w_idx      = r_ptr;
        for (int i = 0; i < els_p; i++) begin
            w_idx = IdW'(wrap_idx(int'(r_ptr) + i));
            if (!o_v && w_reqs[w_idx]) begin
                o_v             = 1'b1;
                o_grants[w_idx] = 1'b1;
                o_grant_id      = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (o_v) begin
            r_ptr <= (o_grant_id == LastId) ? '0 : o_grant_id + IdW'(1);
        end
    end

endmodule

// File: rtl/bsg_mul_share_ctrl.sv
// Shares one pipelined multiplier among several requesters, shadowing its pipeline with valid/id stages.
// Optional performance counters are built when BSG_MUL_SHARE_CTRL_PERF_EN is defined.
module bsg_mul_share_ctrl
    import bsg_mul_share_pkg::*;
#(
    parameter int width_p = WidthDefault,
    parameter int els_p   = ElsDefault,
    parameter int lat_p   = LatDefault
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   x_i,
    input  logic [els_p*width_p-1:0]   y_i,
    input  logic [els_p-1:0]           signed_i,
    output logic [els_p-1:0]           ready_o,
    output logic                       mul_en_o,
    output logic [width_p-1:0]         mul_x_o,
    output logic [width_p-1:0]         mul_y_o,
    output logic                       mul_signed_o,
    input  logic [2*width_p-1:0]       mul_z_i,
    output logic                       v_o,
    output logic [2*width_p-1:0]       z_o,
    output logic [id_width(els_p)-1:0] id_o,
    input  logic                       yumi_i,
    output logic [31:0]                issue_count_o,
    output logic [31:0]                stall_count_o
);

    localparam int IdW = id_width(els_p);

    logic             w_advance;
    logic             w_arb_en;
    logic             w_grant_v;
    logic [els_p-1:0] w_grants;
    logic [IdW-1:0]   w_grant_id;
    logic [lat_p-1:0] r_v;
    logic [IdW-1:0]   r_id [lat_p];

    // A waiting, unconsumed result freezes the whole pipeline, multiplier included.
    assign w_advance = !v_o || yumi_i;
    assign w_arb_en  = w_advance && !reset_i;
    assign mul_en_o  = w_advance;
    assign ready_o   = w_grants;
    assign v_o       = r_v[lat_p-1];
    assign id_o      = r_id[lat_p-1];
    assign z_o       = mul_z_i;

    bsg_arb_round_robin #(
        .els_p(els_p)
    ) u_arb (
        .i_clk      (clk_i),
        .i_reset    (reset_i),
        .i_en       (w_arb_en),
        .i_reqs     (v_i),
        .o_grants   (w_grants),
        .o_grant_id (w_grant_id),
        .o_v        (w_grant_v)
    );

    always_comb begin
        mul_x_o      = '0;
        mul_y_o      = '0;
        mul_signed_o = 1'b0;
        for (int i = 0; i < els_p; i++) begin
            if (w_grants[i]) begin
                mul_x_o      = x_i[i*width_p +: width_p];
                mul_y_o      = y_i[i*width_p +: width_p];
                mul_signed_o = signed_i[i];
            end
        end
    end

    // Stage 0 takes a grant or a bubble; later stages follow the multiplier's own stages.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v <= '0;
            for (int i = 0; i < lat_p; i++) begin
                r_id[i] <= '0;
            end
        end else if (w_advance) begin
            r_v[0]  <= w_grant_v;
            r_id[0] <= w_grant_id;
            for (int i = 1; i < lat_p; i++) begin
                r_v[i]  <= r_v[i-1];
                r_id[i] <= r_id[i-1];
            end
        end
    end

`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
    logic [31:0] r_issue_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_grant_v) begin
                r_issue_count <= r_issue_count + 32'd1;
            end
            if (!w_advance) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign issue_count_o = r_issue_count;
    assign stall_count_o = r_stall_count;
`else
    assign issue_count_o = '0;
    assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_bsg_mul_share_ctrl.sv
// Bench for bsg_mul_share_ctrl paired with a behavioural 4-stage multiplier; table vectors, directed corners, random traffic.
module tb_bsg_mul_share_ctrl;

    localparam int W   = 128;
    localparam int ELS = 2;
    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_i;
    logic [ELS-1:0]      v_i;
    logic [ELS*W-1:0]    x_i;
    logic [ELS*W-1:0]    y_i;
    logic [ELS-1:0]      signed_i;
    logic [ELS-1:0]      ready_o;
    logic                mul_en_o;
    logic [W-1:0]        mul_x_o;
    logic [W-1:0]        mul_y_o;
    logic                mul_signed_o;
    logic [2*W-1:0]      mul_z_i;
    logic                v_o;
    logic [2*W-1:0]      z_o;
    logic [0:0]          id_o;
    logic                yumi_i;
    logic [31:0]         issue_count_o;
    logic [31:0]         stall_count_o;

    bsg_mul_share_ctrl #(
        .width_p(W),
        .els_p  (ELS),
        .lat_p  (LAT)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .x_i          (x_i),
        .y_i          (y_i),
        .signed_i     (signed_i),
        .ready_o      (ready_o),
        .mul_en_o     (mul_en_o),
        .mul_x_o      (mul_x_o),
        .mul_y_o      (mul_y_o),
        .mul_signed_o (mul_signed_o),
        .mul_z_i      (mul_z_i),
        .v_o          (v_o),
        .z_o          (z_o),
        .id_o         (id_o),
        .yumi_i       (yumi_i),
        .issue_count_o(issue_count_o),
        .stall_count_o(stall_count_o)
    );

    function automatic logic [2*W-1:0] mulRef(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [2*W-1:0] ae;
        logic [2*W-1:0] be;
        ae = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        be = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ae * be;
    endfunction

    // Behavioural stand-in for bsg_mul_pipelined: LAT enabled stages.
    logic [2*W-1:0] mulPipe [LAT];
    always @(posedge clk) begin
        if (mul_en_o) begin
            mulPipe[0] <= mulRef(mul_x_o, mul_y_o, mul_signed_o);
            for (int i = 1; i < LAT; i++) mulPipe[i] <= mulPipe[i-1];
        end
    end
    assign mul_z_i = mulPipe[LAT-1];

    // Reference model: in-flight ops in acceptance order, each aging once per advancing cycle.
    logic [2*W-1:0] qZ[$];
    int             qId[$];
    int             qAge[$];
    int             mPtr = 0;
    logic [31:0]    mIssue = '0;
    logic [31:0]    mStall = '0;

    int errors = 0;
    int checks = 0;

    logic [1:0]     sReady;
    logic           sEn;
    logic           sVo;
    logic           sId;
    logic [2*W-1:0] sZ;

    task automatic checkVal(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input logic [1:0] expReady, input logic expEn, input logic expVo);
        checkVal("model ready_o", 256'(sReady), 256'(expReady));
        checkVal("model mul_en_o", 256'(sEn), 256'(expEn));
        checkVal("model v_o", 256'(sVo), 256'(expVo));
        if (expVo) begin
            checkVal("model id_o", 256'(sId), 256'(qId[0]));
            checkVal("model z_o", sZ, qZ[0]);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [1:0] v, input logic [1:0] sg, input logic yumiWant,
                                 input logic [W-1:0] x0, input logic [W-1:0] y0,
                                 input logic [W-1:0] x1, input logic [W-1:0] y1);
        logic       expVo;
        logic       adv;
        logic [1:0] expReady;
        int         g;
        expVo    = (qAge.size() > 0) && (qAge[0] == LAT);
        reset_i  = rst;
        v_i      = v;
        signed_i = sg;
        x_i      = {x1, x0};
        y_i      = {y1, y0};
        yumi_i   = yumiWant && expVo;
        adv      = !expVo || yumi_i;
        g        = -1;
        if (!rst && adv) begin
            for (int i = 0; i < ELS; i++) begin
                int k;
                k = (mPtr + i) % ELS;
                if (g < 0 && v[k[0]]) g = k;
            end
        end
        expReady = (g >= 0) ? (2'b01 << g) : 2'b00;
        #1;
        sReady = ready_o;
        sEn    = mul_en_o;
        sVo    = v_o;
        sId    = id_o[0];
        sZ     = z_o;
        checkOutput(expReady, adv, expVo);
        if (rst) begin
            qZ.delete();
            qId.delete();
            qAge.delete();
            mPtr   = 0;
            mIssue = '0;
            mStall = '0;
        end else if (adv) begin
            if (expVo && yumi_i) begin
                void'(qZ.pop_front());
                void'(qId.pop_front());
                void'(qAge.pop_front());
            end
            foreach (qAge[j]) qAge[j] = qAge[j] + 1;
            if (g >= 0) begin
                qZ.push_back(g == 1 ? mulRef(x1, y1, sg[1]) : mulRef(x0, y0, sg[0]));
                qId.push_back(g);
                qAge.push_back(1);
                mPtr   = (g + 1) % ELS;
                mIssue = mIssue + 32'd1;
            end
        end else begin
            mStall = mStall + 32'd1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [1:0]     v;
        logic [1:0]     sg;
        logic [W-1:0]   x0;
        logic [W-1:0]   y0;
        logic [W-1:0]   x1;
        logic [W-1:0]   y1;
        logic [1:0]     expReady;
        logic           expVo;
        logic           expId;
        logic [2*W-1:0] expZ;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] sg,
                                input logic [W-1:0] x0, input logic [W-1:0] y0,
                                input logic [W-1:0] x1, input logic [W-1:0] y1,
                                input logic [1:0] er, input logic ev, input logic eid, input logic [2*W-1:0] ez);
        vec_t r;
        r.v = v; r.sg = sg; r.x0 = x0; r.y0 = y0; r.x1 = x1; r.y1 = y1;
        r.expReady = er; r.expVo = ev; r.expId = eid; r.expZ = ez;
        return r;
    endfunction

    localparam logic [W-1:0]   NEG2  = {{(W-1){1'b1}}, 1'b0};
    localparam logic [2*W-1:0] ZNEG6 = {{(2*W-3){1'b1}}, 3'b010};

    vec_t tbl [19];

    initial begin
        logic [31:0] expIssue;
        logic [31:0] expStall;

        tbl[0]  = mk(2'b01, 2'b00, 3, 5, 0, 0,    2'b01, 1'b0, 1'b0, 0);
        tbl[1]  = mk(2'b00, 2'b00, 3, 5, 0, 0,    2'b00, 1'b0, 1'b0, 0);
        tbl[2]  = mk(2'b00, 2'b00, 3, 5, 0, 0,    2'b00, 1'b0, 1'b0, 0);
        tbl[3]  = mk(2'b00, 2'b00, 3, 5, 0, 0,    2'b00, 1'b0, 1'b0, 0);
        tbl[4]  = mk(2'b10, 2'b10, 0, 0, NEG2, 3, 2'b10, 1'b1, 1'b0, 15);
        tbl[5]  = mk(2'b00, 2'b00, 0, 0, 0, 0,    2'b00, 1'b0, 1'b0, 0);
        tbl[6]  = mk(2'b00, 2'b00, 0, 0, 0, 0,    2'b00, 1'b0, 1'b0, 0);
        tbl[7]  = mk(2'b00, 2'b00, 0, 0, 0, 0,    2'b00, 1'b0, 1'b0, 0);
        tbl[8]  = mk(2'b11, 2'b00, 7, 2, 4, 4,    2'b01, 1'b1, 1'b1, ZNEG6);
        tbl[9]  = mk(2'b11, 2'b00, 7, 2, 4, 4,    2'b10, 1'b0, 1'b0, 0);
        tbl[10] = mk(2'b11, 2'b00, 7, 2, 4, 4,    2'b01, 1'b0, 1'b0, 0);
        tbl[11] = mk(2'b11, 2'b00, 7, 2, 4, 4,    2'b10, 1'b0, 1'b0, 0);
        tbl[12] = mk(2'b11, 2'b00, 7, 2, 4, 4,    2'b01, 1'b1, 1'b0, 14);
        tbl[13] = mk(2'b11, 2'b00, 7, 2, 4, 4,    2'b10, 1'b1, 1'b1, 16);
        tbl[14] = mk(2'b00, 2'b00, 0, 0, 0, 0,    2'b00, 1'b1, 1'b0, 14);
        tbl[15] = mk(2'b00, 2'b00, 0, 0, 0, 0,    2'b00, 1'b1, 1'b1, 16);
        tbl[16] = mk(2'b00, 2'b00, 0, 0, 0, 0,    2'b00, 1'b1, 1'b0, 14);
        tbl[17] = mk(2'b00, 2'b00, 0, 0, 0, 0,    2'b00, 1'b1, 1'b1, 16);
        tbl[18] = mk(2'b00, 2'b00, 0, 0, 0, 0,    2'b00, 1'b0, 1'b0, 0);

        reset_i  = 1'b1;
        v_i      = '0;
        x_i      = '0;
        y_i      = '0;
        signed_i = '0;
        yumi_i   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 0, 0, 0, 0);

        // Directed vectors straight after reset; the first row also covers the reset state.
        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b0, tbl[i].v, tbl[i].sg, 1'b1, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1);
            if (i == 0) checkVal("reset id_o", 256'(sId), 0);
            checkVal($sformatf("tbl%0d ready_o", i), 256'(sReady), 256'(tbl[i].expReady));
            checkVal($sformatf("tbl%0d v_o", i), 256'(sVo), 256'(tbl[i].expVo));
            if (tbl[i].expVo) begin
                checkVal($sformatf("tbl%0d id_o", i), 256'(sId), 256'(tbl[i].expId));
                checkVal($sformatf("tbl%0d z_o", i), sZ, tbl[i].expZ);
            end
        end

        // Consumer back-pressure: result must hold and nothing new may issue.
        applyStimulus(1'b0, 2'b01, 2'b00, 1'b1, 9, 9, 0, 0);
        repeat (3) applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b11, 2'b00, 1'b0, 1, 1, 1, 1);
            checkVal("stall mul_en_o", 256'(sEn), 0);
            checkVal("stall ready_o", 256'(sReady), 0);
            checkVal("stall v_o", 256'(sVo), 1);
            checkVal("stall id_o", 256'(sId), 0);
            checkVal("stall z_o", sZ, 81);
        end
        applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 0, 0, 0, 0);
        checkVal("resume v_o", 256'(sVo), 1);
        checkVal("resume z_o", sZ, 81);
        applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 0, 0, 0, 0);
        checkVal("after resume v_o", 256'(sVo), 0);

        // Reset with two ops in flight and the pointer on requester 1.
        applyStimulus(1'b0, 2'b10, 2'b00, 1'b1, 0, 0, 5, 6);
        applyStimulus(1'b0, 2'b01, 2'b00, 1'b1, 7, 8, 0, 0);
        applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 1, 1, 1, 1);
        checkVal("reset ready_o", 256'(sReady), 0);
        for (int i = 0; i < LAT + 2; i++) begin
            applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 0, 0, 0, 0);
            checkVal($sformatf("post-reset v_o %0d", i), 256'(sVo), 0);
        end
        applyStimulus(1'b0, 2'b11, 2'b00, 1'b1, 2, 2, 3, 3);
        checkVal("post-reset first grant", 256'(sReady), 256'(2'b01));
        repeat (LAT + 2) applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 0, 0, 0, 0);

        // Counter scenario: five accepts then three stalled cycles.
        applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b01, 2'b00, 1'b1, W'(i + 1), 2, 0, 0);
        repeat (3) applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 0, 0, 0, 0);
        repeat (8) applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 0, 0, 0, 0);
`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
        expIssue = 32'd5;
        expStall = 32'd3;
`else
        expIssue = 32'd0;
        expStall = 32'd0;
`endif
        checkVal("issue_count_o", 256'(issue_count_o), 256'(expIssue));
        checkVal("stall_count_o", 256'(stall_count_o), 256'(expStall));

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0),
                          {$urandom(), $urandom(), $urandom(), $urandom()},
                          {$urandom(), $urandom(), $urandom(), $urandom()},
                          {$urandom(), $urandom(), $urandom(), $urandom()},
                          {$urandom(), $urandom(), $urandom(), $urandom()});
        end
`ifdef BSG_MUL_SHARE_CTRL_PERF_EN
        expIssue = mIssue;
        expStall = mStall;
`else
        expIssue = 32'd0;
        expStall = 32'd0;
`endif
        checkVal("random issue_count_o", 256'(issue_count_o), 256'(expIssue));
        checkVal("random stall_count_o", 256'(stall_count_o), 256'(expStall));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
